// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port synchronous memory.
// Every grant runs ISSUE -> (WAIT for reads) -> RESP, then returns to IDLE to re-arbitrate.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = 4;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          owner_reg;
    logic          last_owner_reg;
    logic          we_reg;
    logic          mem_en_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [1:0]    ack_reg;

    // Port 0 is the CPU, port 1 the loader; index order matches the owner encoding.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];
    logic          grant_sel;
    logic          rd_done;

    assign req_vec      = {ldr_req, cpu_req};
    assign we_vec       = {ldr_we, cpu_we};
    assign addr_vec[0]  = cpu_addr;
    assign addr_vec[1]  = ldr_addr;
    assign wdata_vec[0] = cpu_wdata;
    assign wdata_vec[1] = ldr_wdata;

    // On a tie the port that did not win last time gets the memory.
    assign grant_sel = (&req_vec) ? ~last_owner_reg : req_vec[1];
    assign rd_done   = (state_reg == WAIT) && (cnt_reg == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            we_reg         <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            ack_reg        <= '0;
        end else begin
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            ack_reg    <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        owner_reg      <= grant_sel;
                        last_owner_reg <= grant_sel;
                        we_reg         <= we_vec[grant_sel];
                        mem_en_reg     <= 1'b1;
                        mem_we_reg     <= we_vec[grant_sel];
                        mem_addr_reg   <= addr_vec[grant_sel];
                        mem_wdata_reg  <= wdata_vec[grant_sel];
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        ack_reg[owner_reg] <= 1'b1;
                        state_reg          <= RESP;
                    end else begin
                        cnt_reg   <= CW'(MEM_LAT);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        ack_reg[owner_reg] <= 1'b1;
                        state_reg          <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Each port keeps its last read data; only its own reads overwrite it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DW-1:0] rdata_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_reg <= '0;
            end else if (rd_done && (owner_reg == 1'(gi))) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = g_port[0].rdata_reg;
    assign ldr_rdata = g_port[1].rdata_reg;
    assign cpu_ack   = ack_reg[0];
    assign ldr_ack   = ack_reg[1];
    assign cpu_stall = cpu_req & ~ack_reg[0];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios plus randomized two-port traffic
// checked against a cycle-arithmetic model; two extra instances cover MEM_LAT=1 and 15.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Memory model: 256 words (low address byte), read data valid only in cycle 1+LAT.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic          pv [LAT];
    logic [7:0]    pa [LAT];

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A00_0100 + 32'(i) * 32'h0001_0203);
    endfunction

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_we;
        pa[0] <= mem_addr[7:0];
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign mem_rdata = pv[LAT-1] ? mem[pa[LAT-1]] : {16'hBAD0, cyc[15:0]};

    // Latency-corner instances: CPU port only, memory answers only in the exact cycle.
    logic          a1_req = 1'b0, a15_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic          a1_ack, a1_stall, a1_lack, a1_en, a1_we, a1_busy, a1_owner;
    logic          a15_ack, a15_stall, a15_lack, a15_en, a15_we, a15_busy, a15_owner;
    logic [DW-1:0] a1_rdata, a1_lrdata, a1_wdata, a1_mrdata;
    logic [DW-1:0] a15_rdata, a15_lrdata, a15_wdata, a15_mrdata;
    logic [AW-1:0] a1_maddr, a15_maddr;
    int            a1_cnt, a15_cnt;

    always @(posedge clk) begin
        if (!rst_n) a1_cnt <= 0;
        else if (a1_en) a1_cnt <= 1;
        else if (a1_cnt != 0) a1_cnt <= a1_cnt + 1;
    end
    always @(posedge clk) begin
        if (!rst_n) a15_cnt <= 0;
        else if (a15_en) a15_cnt <= 1;
        else if (a15_cnt != 0) a15_cnt <= a15_cnt + 1;
    end
    assign a1_mrdata  = (a1_cnt == 1)   ? (32'hC0DE_0000 | 32'(a1_maddr))  : 32'hFFFF_FFFF;
    assign a15_mrdata = (a15_cnt == 15) ? (32'hC0DE_0000 | 32'(a15_maddr)) : 32'hFFFF_FFFF;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(a1_req), .cpu_we(1'b0), .cpu_addr(a_addr), .cpu_wdata('0),
        .cpu_ack(a1_ack), .cpu_rdata(a1_rdata), .cpu_stall(a1_stall),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr('0), .ldr_wdata('0),
        .ldr_ack(a1_lack), .ldr_rdata(a1_lrdata),
        .mem_en(a1_en), .mem_we(a1_we), .mem_addr(a1_maddr), .mem_wdata(a1_wdata),
        .mem_rdata(a1_mrdata), .busy(a1_busy), .owner(a1_owner)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(15)) dut_lat15 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(a15_req), .cpu_we(1'b0), .cpu_addr(a_addr), .cpu_wdata('0),
        .cpu_ack(a15_ack), .cpu_rdata(a15_rdata), .cpu_stall(a15_stall),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr('0), .ldr_wdata('0),
        .ldr_ack(a15_lack), .ldr_rdata(a15_lrdata),
        .mem_en(a15_en), .mem_we(a15_we), .mem_addr(a15_maddr), .mem_wdata(a15_wdata),
        .mem_rdata(a15_mrdata), .busy(a15_busy), .owner(a15_owner)
    );

    // Leaves the bench just after a rising edge, in the first IDLE cycle after reset.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0; a1_req = 1'b0; a15_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (mem_en !== 1'b0)    begin errors++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL rst_cpu_ack got %b want 0", cpu_ack); end
        checks++; if (ldr_ack !== 1'b0)   begin errors++; $display("FAIL rst_ldr_ack got %b want 0", ldr_ack); end
        checks++; if (cpu_rdata !== '0)   begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
        checks++; if (ldr_rdata !== '0)   begin errors++; $display("FAIL rst_ldr_rdata got %h want 0", ldr_rdata); end
        checks++; if (owner !== 1'b0)     begin errors++; $display("FAIL rst_owner got %b want 0", owner); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_cpu_stall got %b want 1", cpu_stall); end
        @(posedge clk); #1;
        cpu_req = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (mem_en !== (c == 1))    begin errors++; $display("FAIL rd_mem_en c%0d got %b want %b", c, mem_en, (c == 1)); end
            checks++; if (cpu_ack !== (c == 4))   begin errors++; $display("FAIL rd_cpu_ack c%0d got %b want %b", c, cpu_ack, (c == 4)); end
            checks++; if (cpu_stall !== (c <= 3)) begin errors++; $display("FAIL rd_cpu_stall c%0d got %b want %b", c, cpu_stall, (c <= 3)); end
            checks++; if (busy !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL rd_busy c%0d got %b want %b", c, busy, (c >= 1 && c <= 4)); end
            if (c == 1) begin
                checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_mem_addr got %h want 0010", mem_addr); end
                checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL rd_mem_we got %b want 0", mem_we); end
            end
            if (c >= 4) begin
                checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_cpu_rdata c%0d got %h want deadbeef", c, cpu_rdata); end
            end
            @(posedge clk); #1;
            if (c == 4) cpu_req = 1'b0;
        end
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0100; ldr_wdata = 32'h12345678;
        ref_mem[8'h00] = 32'h12345678;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (mem_en !== (c == 1))  begin errors++; $display("FAIL wr_mem_en c%0d got %b want %b", c, mem_en, (c == 1)); end
            checks++; if (ldr_ack !== (c == 2)) begin errors++; $display("FAIL wr_ldr_ack c%0d got %b want %b", c, ldr_ack, (c == 2)); end
            checks++; if (cpu_ack !== 1'b0)     begin errors++; $display("FAIL wr_cpu_ack c%0d got %b want 0", c, cpu_ack); end
            checks++; if (cpu_stall !== 1'b0)   begin errors++; $display("FAIL wr_cpu_stall c%0d got %b want 0", c, cpu_stall); end
            checks++; if (ldr_rdata !== '0)     begin errors++; $display("FAIL wr_ldr_rdata c%0d got %h want 0", c, ldr_rdata); end
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_cpu_rdata c%0d got %h want deadbeef", c, cpu_rdata); end
            if (c == 1) begin
                checks++; if (mem_we !== 1'b1)            begin errors++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
                checks++; if (mem_addr !== 16'h0100)      begin errors++; $display("FAIL wr_mem_addr got %h want 0100", mem_addr); end
                checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_mem_wdata got %h want 12345678", mem_wdata); end
                checks++; if (owner !== 1'b1)             begin errors++; $display("FAIL wr_owner got %b want 1", owner); end
            end
            @(posedge clk); #1;
            if (c == 2) ldr_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0005;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            checks++; if (mem_en !== (c == 1 || c == 6)) begin errors++; $display("FAIL ct_mem_en c%0d got %b want %b", c, mem_en, (c == 1 || c == 6)); end
            checks++; if (cpu_ack !== (c == 4)) begin errors++; $display("FAIL ct_cpu_ack c%0d got %b want %b", c, cpu_ack, (c == 4)); end
            checks++; if (ldr_ack !== (c == 9)) begin errors++; $display("FAIL ct_ldr_ack c%0d got %b want %b", c, ldr_ack, (c == 9)); end
            checks++; if (busy !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin errors++; $display("FAIL ct_busy c%0d got %b", c, busy); end
            if (c == 1) begin
                checks++; if (owner !== 1'b0 || mem_addr !== 16'h0003) begin errors++; $display("FAIL ct_grant1 got owner %b addr %h want 0 0003", owner, mem_addr); end
            end
            if (c == 6) begin
                checks++; if (owner !== 1'b1 || mem_addr !== 16'h0005) begin errors++; $display("FAIL ct_grant2 got owner %b addr %h want 1 0005", owner, mem_addr); end
            end
            if (c == 4) begin
                checks++; if (cpu_rdata !== ref_mem[3]) begin errors++; $display("FAIL ct_cpu_rdata got %h want %h", cpu_rdata, ref_mem[3]); end
            end
            if (c == 9) begin
                checks++; if (ldr_rdata !== ref_mem[5]) begin errors++; $display("FAIL ct_ldr_rdata got %h want %h", ldr_rdata, ref_mem[5]); end
            end
            @(posedge clk); #1;
            if (c == 4) cpu_req = 1'b0;
            if (c == 9) ldr_req = 1'b0;
        end
    endtask

    task automatic test_midwait_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mw_cpu_ack c%0d got %b want 0", c, cpu_ack); end
            if (c == 1) begin
                checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL mw_issue got %b want 1", mem_en); end
            end
            if (c == 3) begin
                checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL mw_stall_in_rst got %b want 1", cpu_stall); end
                checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL mw_busy_wait got %b want 1", busy); end
            end
            if (c >= 4) begin
                checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mw_busy c%0d got %b want 0", c, busy); end
                checks++; if (mem_en !== 1'b0)  begin errors++; $display("FAIL mw_mem_en c%0d got %b want 0", c, mem_en); end
                checks++; if (cpu_rdata !== '0) begin errors++; $display("FAIL mw_cpu_rdata c%0d got %h want 0", c, cpu_rdata); end
            end
            @(posedge clk); #1;
            if (c == 2) rst_n = 1'b0;
            if (c == 3) begin rst_n = 1'b1; cpu_req = 1'b0; end
        end
        cpu_req = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (cpu_ack !== (c == 4)) begin errors++; $display("FAIL mw_rereq_ack c%0d got %b want %b", c, cpu_ack, (c == 4)); end
            if (c == 4) begin
                checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mw_rereq_rdata got %h want deadbeef", cpu_rdata); end
            end
            @(posedge clk); #1;
            if (c == 4) cpu_req = 1'b0;
        end
    endtask

    // Model: an access granted in IDLE cycle t issues at t+1 and acks at t+2 (write)
    // or t+2+LAT (read); the arbiter is free again at ack+1; ties go to !last winner.
    task automatic test_traffic(input int n_acc, input int pct, input bit check_alt);
        int m_free, gnt_t, ack_t, done, t, gcount;
        bit in_fl, m_last, g_port, g_we, c_acked, l_acked, exp_ca, exp_la;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata, g_rdata, exp_crd, exp_lrd;
        do_reset();
        m_free = cyc; m_last = 1'b1; in_fl = 1'b0; done = 0; gcount = 0;
        gnt_t = 0; ack_t = 0; g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_rdata = '0;
        exp_crd = '0; exp_lrd = '0; c_acked = 1'b0; l_acked = 1'b0;
        for (int k = 0; k < 4000 && done < n_acc; k++) begin
            if (!cpu_req || c_acked) begin
                cpu_req = ($urandom_range(99) < pct);
                cpu_we = 1'($urandom_range(1)); cpu_addr = AW'($urandom_range(15)); cpu_wdata = $urandom;
            end
            if (!ldr_req || l_acked) begin
                ldr_req = ($urandom_range(99) < pct);
                ldr_we = 1'($urandom_range(1)); ldr_addr = AW'($urandom_range(15)); ldr_wdata = $urandom;
            end
            @(negedge clk);
            t = cyc;
            if (!in_fl && t >= m_free && (cpu_req || ldr_req)) begin
                g_port  = (cpu_req && ldr_req) ? !m_last : ldr_req;
                m_last  = g_port;
                in_fl   = 1'b1;
                gnt_t   = t;
                g_we    = g_port ? ldr_we : cpu_we;
                g_addr  = g_port ? ldr_addr : cpu_addr;
                g_wdata = g_port ? ldr_wdata : cpu_wdata;
                ack_t   = t + (g_we ? 2 : LAT + 2);
                m_free  = ack_t + 1;
                if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
                else      g_rdata = ref_mem[g_addr[7:0]];
            end
            exp_ca = in_fl && (t == ack_t) && !g_port;
            exp_la = in_fl && (t == ack_t) && g_port;
            if (in_fl && t == ack_t && !g_we) begin
                if (g_port) exp_lrd = g_rdata;
                else        exp_crd = g_rdata;
            end
            checks++; if (cpu_ack !== exp_ca)   begin errors++; $display("FAIL trf_cpu_ack cyc %0d got %b want %b", t, cpu_ack, exp_ca); end
            checks++; if (ldr_ack !== exp_la)   begin errors++; $display("FAIL trf_ldr_ack cyc %0d got %b want %b", t, ldr_ack, exp_la); end
            checks++; if (cpu_rdata !== exp_crd) begin errors++; $display("FAIL trf_cpu_rdata cyc %0d got %h want %h", t, cpu_rdata, exp_crd); end
            checks++; if (ldr_rdata !== exp_lrd) begin errors++; $display("FAIL trf_ldr_rdata cyc %0d got %h want %h", t, ldr_rdata, exp_lrd); end
            checks++; if (cpu_stall !== (cpu_req && !exp_ca)) begin errors++; $display("FAIL trf_cpu_stall cyc %0d got %b want %b", t, cpu_stall, (cpu_req && !exp_ca)); end
            checks++; if (busy !== (in_fl && t > gnt_t)) begin errors++; $display("FAIL trf_busy cyc %0d got %b want %b", t, busy, (in_fl && t > gnt_t)); end
            checks++; if (mem_en !== (in_fl && t == gnt_t + 1)) begin errors++; $display("FAIL trf_mem_en cyc %0d got %b want %b", t, mem_en, (in_fl && t == gnt_t + 1)); end
            if (in_fl && t == gnt_t + 1) begin
                checks++; if (owner !== g_port)   begin errors++; $display("FAIL trf_owner cyc %0d got %b want %b", t, owner, g_port); end
                checks++; if (mem_we !== g_we)    begin errors++; $display("FAIL trf_mem_we cyc %0d got %b want %b", t, mem_we, g_we); end
                checks++; if (mem_addr !== g_addr) begin errors++; $display("FAIL trf_mem_addr cyc %0d got %h want %h", t, mem_addr, g_addr); end
                if (g_we) begin
                    checks++; if (mem_wdata !== g_wdata) begin errors++; $display("FAIL trf_mem_wdata cyc %0d got %h want %h", t, mem_wdata, g_wdata); end
                end
                if (check_alt) begin
                    checks++; if (owner !== gcount[0]) begin errors++; $display("FAIL trf_alternate grant %0d got %b want %b", gcount, owner, gcount[0]); end
                end
                gcount++;
            end
            c_acked = exp_ca;
            l_acked = exp_la;
            if (in_fl && t == ack_t) begin
                in_fl = 1'b0;
                done++;
            end
            @(posedge clk); #1;
        end
        checks++; if (done < n_acc) begin errors++; $display("FAIL trf_timeout got %0d accesses want %0d", done, n_acc); end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
    endtask

    task automatic test_latency_builds();
        logic [DW-1:0] exp;
        a_addr = AW'($urandom_range(16'hFFFF));
        exp = 32'hC0DE_0000 | 32'(a_addr);
        a1_req = 1'b1; a15_req = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            checks++; if (a1_en !== (c == 1))    begin errors++; $display("FAIL lat1_mem_en c%0d got %b want %b", c, a1_en, (c == 1)); end
            checks++; if (a15_en !== (c == 1))   begin errors++; $display("FAIL lat15_mem_en c%0d got %b want %b", c, a15_en, (c == 1)); end
            checks++; if (a1_ack !== (c == 3))   begin errors++; $display("FAIL lat1_ack c%0d got %b want %b", c, a1_ack, (c == 3)); end
            checks++; if (a15_ack !== (c == 17)) begin errors++; $display("FAIL lat15_ack c%0d got %b want %b", c, a15_ack, (c == 17)); end
            if (c == 3) begin
                checks++; if (a1_rdata !== exp) begin errors++; $display("FAIL lat1_rdata got %h want %h", a1_rdata, exp); end
            end
            if (c == 17) begin
                checks++; if (a15_rdata !== exp) begin errors++; $display("FAIL lat15_rdata got %h want %h", a15_rdata, exp); end
            end
            @(posedge clk); #1;
            if (c == 3)  a1_req = 1'b0;
            if (c == 17) a15_req = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_midwait_reset();
        test_traffic(6, 100, 1'b1);
        test_traffic(60, 40, 1'b0);
        test_latency_builds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU's single-port synchronous memory. It shares the memory between the multicycle CPU datapath (fetch/load/store accesses) and a program-loader/debug port. Each granted access runs through a fixed issue / wait / respond sequence. The block also drives a stall so the control FSM holds its state until its access completes.

## Interface
- AW, 16, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; valid with cpu_ack, held until the next CPU read ack
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AW/DW  loader request group; same rules as CPU
- ldr_ack  out  1  loader completion pulse
- ldr_rdata  out  DW  loader read data; same hold rule
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  state != IDLE
- owner  out  1  0 = CPU, 1 = loader; meaningful only while busy

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests.
  - None pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: grant the port != last_owner (round-robin).
  - On grant: capture we/addr/wdata into registers, set owner, update last_owner, go to ISSUE.
- ISSUE: mem_en=1, with mem_we/mem_addr/mem_wdata taken from the captured values.
  - Write: go to RESP.
  - Read: load the wait counter with MEM_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. When the counter == 1, latch mem_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ack for one cycle, go to IDLE. Requests are not sampled in RESP.
- Requester obligations:
  - Drop req on the edge ending the ack cycle.
  - Inputs must stay stable while req is high and ack has not yet been seen.
  - A request held through the following IDLE cycle is treated as a new access.
- No other arbitration changes: a granted access always completes, and the other port waits.
- rdata registers update only on reads of their own port. Writes leave them unchanged.
- Reset (rst_n=0 at an edge), from any state including mid-WAIT:
  - state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=0, ldr_ack=0, cpu_rdata=0, ldr_rdata=0.
  - owner=0, counter=0, last_owner=1, so the CPU wins the first tie.
  - In-flight accesses are discarded without ack. Requesters re-request after reset.
- busy resets to 0. cpu_stall follows its equation, so it is 1 during reset if cpu_req=1.

## Timing
- Cycle 0: req high in IDLE.
- Cycle 1: ISSUE, mem_en=1.
- Write: ack in cycle 2. Latency is 2 cycles.
- Read:
  - WAIT occupies cycles 2..1+MEM_LAT.
  - mem_rdata is sampled at the end of cycle 1+MEM_LAT.
  - ack and rdata are valid in cycle 2+MEM_LAT. Latency is MEM_LAT+2 cycles.
- Minimum spacing between mem_en pulses: 3 cycles for writes (ISSUE, RESP, IDLE), MEM_LAT+3 cycles for reads.
- Losing requester under contention: its grant comes in the IDLE cycle right after the winner's RESP.
- mem_en is never asserted outside ISSUE. The two acks are never high together.

## Test plan
- Reset, then CPU read with MEM_LAT=2: cpu_addr=0x0010, memory returns 0xDEADBEEF.
  - Required: mem_en=1 with mem_addr=0x0010 in cycle 1.
  - Required: cpu_ack=1 with cpu_rdata=0xDEADBEEF in cycle 4, cpu_stall=1 in cycles 0..3.
- Loader write ldr_addr=0x0100, ldr_wdata=0x12345678: mem_en=mem_we=1 in cycle 1, ldr_ack in cycle 2, ldr_rdata unchanged, cpu_stall=0 throughout.
- Both ports request reads in the first cycle after reset: CPU granted first (owner=0), cpu_ack in cycle 4. Loader granted in cycle 5, ldr_ack in cycle 9.
- Continuous contention over 6 accesses: grants alternate CPU, loader, CPU, loader…, with no port granted twice in a row while the other is pending.
- rst_n=0 in the second WAIT cycle of a CPU read: next cycle busy=0, mem_en=0, no cpu_ack ever issued, cpu_rdata=0. A re-request completes normally in MEM_LAT+2 cycles.
- MEM_LAT=1 and MEM_LAT=15 builds: read ack lands exactly in cycle 3 and cycle 17 respectively, with correct data.
